// File: rtl/cpu_host_loader.sv
// Host-side session controller: streams a program into instruction memory,
// runs the CPU for a set number of cycles, then dumps a data-memory region.
module cpu_host_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int LW         = 11
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          start,
  input  logic [LW-1:0] prog_len,
  input  logic [31:0]   run_cycles,
  input  logic [LW-1:0] dump_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          cpu_enable,
  output logic [63:0]   addr_ext,
  output logic          wen_ext,
  output logic          ren_ext,
  output logic [31:0]   wdata_ext,
  output logic [63:0]   addr_ext_2,
  output logic          wen_ext_2,
  output logic          ren_ext_2,
  output logic [63:0]   wdata_ext_2,
  input  logic [63:0]   rdata_ext_2,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WLAST, S_RUN, S_RD, S_WAIT, S_DONE
  } state_t;

  state_t        state;
  logic [LW-1:0] cnt, cnt_inc, plen, dlen, p_clamp, d_clamp;
  logic [31:0]   rcnt;

  always_comb begin
    p_clamp = (prog_len > LW'(IMEM_DEPTH)) ? LW'(IMEM_DEPTH) : prog_len;
    d_clamp = (dump_len > LW'(DMEM_DEPTH)) ? LW'(DMEM_DEPTH) : dump_len;
    cnt_inc = cnt + 1'b1;
  end

  assign ren_ext     = 1'b0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;

  // Phase skipping is resolved at every phase exit so no idle cycle is
  // spent in an empty phase; the word counter is reused for load and dump.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      plen       <= '0;
      dlen       <= '0;
      rcnt       <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      cpu_enable <= 1'b0;
      addr_ext   <= '0;
      wen_ext    <= 1'b0;
      wdata_ext  <= '0;
      addr_ext_2 <= '0;
      ren_ext_2  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          plen <= p_clamp;
          dlen <= d_clamp;
          rcnt <= run_cycles;
          cnt  <= '0;
          busy <= 1'b1;
          if (p_clamp != '0) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end else if (run_cycles != '0) begin
            state      <= S_RUN;
            cpu_enable <= 1'b1;
          end else if (d_clamp != '0) begin
            state      <= S_RD;
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= '0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_LOAD: if (in_valid) begin
          wen_ext   <= 1'b1;
          addr_ext  <= {{(62-LW){1'b0}}, cnt, 2'b00};
          wdata_ext <= in_data;
          cnt       <= cnt_inc;
          if (cnt_inc == plen) begin
            state    <= S_WLAST;
            in_ready <= 1'b0;
          end
        end else begin
          wen_ext   <= 1'b0;
          addr_ext  <= '0;
          wdata_ext <= '0;
        end
        S_WLAST: begin
          wen_ext   <= 1'b0;
          addr_ext  <= '0;
          wdata_ext <= '0;
          if (rcnt != '0) begin
            state      <= S_RUN;
            cpu_enable <= 1'b1;
          end else if (dlen != '0) begin
            state      <= S_RD;
            cnt        <= '0;
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= '0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_RUN: begin
          rcnt <= rcnt - 32'd1;
          if (rcnt == 32'd1) begin
            cpu_enable <= 1'b0;
            if (dlen != '0) begin
              state      <= S_RD;
              cnt        <= '0;
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RD: begin
          ren_ext_2  <= 1'b0;
          addr_ext_2 <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= rdata_ext_2;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          cnt       <= cnt_inc;
          if (cnt_inc == dlen) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state      <= S_RD;
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= {{(61-LW){1'b0}}, cnt_inc, 3'b000};
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Randomized session bench for cpu_host_loader with a behavioural session
// model, data-memory model and per-cycle protocol monitor.
module tb_cpu_host_loader;
  localparam int IMEM_DEPTH = 512;
  localparam int DMEM_DEPTH = 1024;
  localparam int LW         = 11;

  logic          clk = 1'b0;
  logic          arst, start, in_valid, in_ready, out_valid, out_ready;
  logic          cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [LW-1:0] prog_len, dump_len;
  logic [31:0]   run_cycles, in_data, wdata_ext;
  logic [63:0]   out_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;

  cpu_host_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .LW(LW)) dut (
    .clk(clk), .arst(arst), .start(start), .prog_len(prog_len),
    .run_cycles(run_cycles), .dump_len(dump_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [63:0] dmem [DMEM_DEPTH];
  logic [31:0] stream [600];

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[12:3]] : {$urandom, $urandom};

  int          hs_cyc_q[$], wr_cyc_q[$], out_cyc_q[$], done_cyc_q[$], en_cyc_q[$];
  logic [63:0] wr_addr_q[$], rd_addr_q[$], out_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_cyc_q[$];
  int          busy_cnt = 0, viol_fixed = 0, viol_excl = 0, viol_hold = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (!arst) begin
      if (in_valid && in_ready) hs_cyc_q.push_back(cyc);
      if (wen_ext) begin
        wr_addr_q.push_back(addr_ext);
        wr_data_q.push_back(wdata_ext);
        wr_cyc_q.push_back(cyc);
      end
      if (ren_ext_2) begin
        rd_addr_q.push_back(addr_ext_2);
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        out_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (cpu_enable) en_cyc_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (wen_ext_2 || ren_ext || wdata_ext_2 != '0 ||
          (!wen_ext && (addr_ext != '0 || wdata_ext != '0)) ||
          (!ren_ext_2 && addr_ext_2 != '0)) viol_fixed++;
      if (cpu_enable && (wen_ext || ren_ext_2)) viol_excl++;
      if (prev_stall && (!out_valid || out_data != prev_data)) viol_hold++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 0;
    end
  end

  int b_hs, b_wr, b_rd, b_out, b_done, b_en, b_busy, b_vf, b_vx, b_vh, s_start;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic run_session(input int pl, input int rc, input int dl,
                             input int vp, input int rp, input int stall);
    int ovc, taken;
    bit to;
    @(posedge clk); #1;
    b_hs = hs_cyc_q.size(); b_wr = wr_addr_q.size(); b_rd = rd_addr_q.size();
    b_out = out_q.size(); b_done = done_cyc_q.size(); b_en = en_cyc_q.size();
    b_busy = busy_cnt; b_vf = viol_fixed; b_vx = viol_excl; b_vh = viol_hold;
    start = 1'b1; prog_len = LW'(pl); run_cycles = 32'(rc); dump_len = LW'(dl);
    s_start = cyc; ovc = 0; to = 1;
    for (int k = 0; k < 8000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc_q.size() > b_done) begin to = 0; break; end
      // Length inputs are scrambled and stray starts issued mid-session.
      start = ($urandom_range(3) == 0);
      prog_len = LW'($urandom); run_cycles = $urandom; dump_len = LW'($urandom);
      taken = hs_cyc_q.size() - b_hs;
      in_valid = ($urandom_range(99) < vp);
      in_data = stream[taken % 600];
      if (out_valid) ovc++;
      out_ready = (ovc > stall) && ($urandom_range(99) < rp);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL session_timeout: done=%0d required 1", done_cyc_q.size() - b_done);
    end
  endtask

  task automatic test_reset();
    logic [296:0] outs;
    #12;
    outs = {cpu_enable, in_ready, out_valid, busy, done, wen_ext, ren_ext, wen_ext_2,
            ren_ext_2, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h required 0", outs);
    end
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] w [3];
    w[0] = 32'h00000013; w[1] = 32'h00100093; w[2] = 32'h00208133;
    for (int i = 0; i < 600; i++) stream[i] = (i < 3) ? w[i] : $urandom;
    run_session(3, 0, 0, 100, 100, 0);
    vectors++;
    if (wr_addr_q.size() - b_wr !== 3) begin
      miscompares++;
      $display("FAIL load_count: got %0d required 3", wr_addr_q.size() - b_wr);
    end
    for (int i = 0; i < imin(3, wr_addr_q.size() - b_wr); i++) begin
      vectors++;
      if (wr_addr_q[b_wr+i] !== 64'(4*i) || wr_data_q[b_wr+i] !== w[i] ||
          wr_cyc_q[b_wr+i] !== s_start + 2 + i) begin
        miscompares++;
        $display("FAIL load_word%0d: got a=%0h d=%0h c=%0d required a=%0h d=%0h c=%0d", i,
                 wr_addr_q[b_wr+i], wr_data_q[b_wr+i], wr_cyc_q[b_wr+i], 4*i, w[i], s_start+2+i);
      end
    end
    vectors++;
    if (hs_cyc_q.size() - b_hs !== 3) begin
      miscompares++;
      $display("FAIL load_in_ready_drop: accepted %0d required 3", hs_cyc_q.size() - b_hs);
    end
  endtask

  task automatic test_run();
    int n;
    run_session(0, 10, 0, 50, 100, 0);
    n = en_cyc_q.size() - b_en;
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL run_count: got %0d required 10", n);
    end
    if (n > 0) begin
      vectors++;
      if (en_cyc_q[b_en] !== s_start + 1 || en_cyc_q[b_en+n-1] !== s_start + 10) begin
        miscompares++;
        $display("FAIL run_window: got %0d..%0d required %0d..%0d",
                 en_cyc_q[b_en], en_cyc_q[b_en+n-1], s_start+1, s_start+10);
      end
    end
    vectors++;
    if (viol_excl - b_vx !== 0 || wr_addr_q.size() !== b_wr || rd_addr_q.size() !== b_rd) begin
      miscompares++;
      $display("FAIL run_no_strobe: excl=%0d wr=%0d rd=%0d required 0", viol_excl - b_vx,
               wr_addr_q.size() - b_wr, rd_addr_q.size() - b_rd);
    end
  endtask

  task automatic test_dump();
    dmem[0] = 64'hDEAD; dmem[1] = 64'hBEEF;
    run_session(0, 0, 2, 0, 100, 5);
    vectors++;
    if (rd_addr_q.size() - b_rd !== 2 || rd_addr_q[b_rd] !== 64'd0 || rd_addr_q[b_rd+1] !== 64'd8) begin
      miscompares++;
      $display("FAIL dump_read_addr: got n=%0d %0h %0h required 2 0 8", rd_addr_q.size() - b_rd,
               rd_addr_q[b_rd], rd_addr_q[b_rd+1]);
    end
    vectors++;
    if (out_q.size() - b_out !== 2 || out_q[b_out] !== 64'hDEAD || out_q[b_out+1] !== 64'hBEEF) begin
      miscompares++;
      $display("FAIL dump_data: got n=%0d %0h %0h required 2 dead beef", out_q.size() - b_out,
               out_q[b_out], out_q[b_out+1]);
    end
    vectors++;
    if (out_cyc_q[b_out] !== s_start + 8 || out_cyc_q[b_out+1] !== s_start + 11) begin
      miscompares++;
      $display("FAIL dump_timing: got %0d %0d required %0d %0d", out_cyc_q[b_out],
               out_cyc_q[b_out+1], s_start+8, s_start+11);
    end
    vectors++;
    if (viol_hold - b_vh !== 0) begin
      miscompares++;
      $display("FAIL dump_hold: got %0d unstable cycles required 0", viol_hold - b_vh);
    end
    vectors++;
    if (done_cyc_q[b_done] !== s_start + 12) begin
      miscompares++;
      $display("FAIL dump_done: got %0d required %0d", done_cyc_q[b_done], s_start+12);
    end
  endtask

  task automatic test_empty();
    run_session(0, 0, 0, 100, 100, 0);
    vectors++;
    if (busy_cnt - b_busy !== 1 || done_cyc_q.size() - b_done !== 1 ||
        done_cyc_q[b_done] !== s_start + 1) begin
      miscompares++;
      $display("FAIL empty_session: busy=%0d done_n=%0d done_c=%0d required 1 1 %0d",
               busy_cnt - b_busy, done_cyc_q.size() - b_done, done_cyc_q[b_done], s_start+1);
    end
    vectors++;
    if (wr_addr_q.size() !== b_wr || rd_addr_q.size() !== b_rd || en_cyc_q.size() !== b_en) begin
      miscompares++;
      $display("FAIL empty_strobes: wr=%0d rd=%0d en=%0d required 0", wr_addr_q.size() - b_wr,
               rd_addr_q.size() - b_rd, en_cyc_q.size() - b_en);
    end
  endtask

  task automatic test_clamp();
    int n;
    for (int i = 0; i < 600; i++) stream[i] = $urandom;
    run_session(4000, 0, 0, 100, 100, 0);
    n = wr_addr_q.size() - b_wr;
    vectors++;
    if (n !== IMEM_DEPTH || hs_cyc_q.size() - b_hs !== IMEM_DEPTH) begin
      miscompares++;
      $display("FAIL clamp_prog_count: got wr=%0d hs=%0d required 512", n, hs_cyc_q.size() - b_hs);
    end
    vectors++;
    if (n > 0 && (wr_addr_q[b_wr+n-1] !== 64'd2044 || wr_data_q[b_wr+n-1] !== stream[n-1])) begin
      miscompares++;
      $display("FAIL clamp_prog_last: got a=%0h d=%0h required a=7fc d=%0h",
               wr_addr_q[b_wr+n-1], wr_data_q[b_wr+n-1], stream[n-1]);
    end
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = {$urandom, $urandom};
    run_session(0, 0, 1500, 100, 100, 0);
    n = out_q.size() - b_out;
    vectors++;
    if (n !== DMEM_DEPTH || rd_addr_q.size() - b_rd !== DMEM_DEPTH) begin
      miscompares++;
      $display("FAIL clamp_dump_count: got out=%0d rd=%0d required 1024", n, rd_addr_q.size() - b_rd);
    end
    vectors++;
    if (n > 0 && (out_q[b_out+n-1] !== dmem[n-1] || rd_addr_q[b_rd+n-1] !== 64'(8*(n-1)))) begin
      miscompares++;
      $display("FAIL clamp_dump_last: got d=%0h a=%0h required d=%0h a=%0h", out_q[b_out+n-1],
               rd_addr_q[b_rd+n-1], dmem[n-1], 8*(n-1));
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int pl, rc, dl, ew, ed, nw, ne, nr, no, e_done, e_en, e_rd, bad;
      pl = ($urandom_range(5) == 0) ? int'($urandom_range(2047)) : int'($urandom_range(40));
      rc = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(1, 30));
      dl = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, 20));
      for (int i = 0; i < 600; i++) stream[i] = $urandom;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = {$urandom, $urandom};
      run_session(pl, rc, dl, 30 + $urandom_range(70), 30 + $urandom_range(70), 0);
      ew = imin(pl, IMEM_DEPTH); ed = imin(dl, DMEM_DEPTH);
      nw = wr_addr_q.size() - b_wr; ne = en_cyc_q.size() - b_en;
      nr = rd_addr_q.size() - b_rd; no = out_q.size() - b_out;
      vectors++;
      if (nw !== ew || hs_cyc_q.size() - b_hs !== ew) begin
        miscompares++;
        $display("FAIL rnd%0d_write_count: got wr=%0d hs=%0d required %0d", s, nw,
                 hs_cyc_q.size() - b_hs, ew);
      end
      bad = 0;
      for (int i = 0; i < imin(nw, ew); i++)
        if (wr_addr_q[b_wr+i] !== 64'(4*i) || wr_data_q[b_wr+i] !== stream[i] ||
            wr_cyc_q[b_wr+i] !== hs_cyc_q[b_hs+i] + 1) bad++;
      vectors++;
      if (bad !== 0) begin
        miscompares++;
        $display("FAIL rnd%0d_write_words: got %0d bad words required 0", s, bad);
      end
      e_en = (ew > 0 && nw > 0) ? wr_cyc_q[b_wr+nw-1] + 1 : s_start + 1;
      vectors++;
      if (ne !== rc || (ne > 0 && (en_cyc_q[b_en] !== e_en || en_cyc_q[b_en+ne-1] !== e_en + ne - 1))) begin
        miscompares++;
        $display("FAIL rnd%0d_run: got n=%0d first=%0d required n=%0d first=%0d contiguous", s,
                 ne, (ne > 0) ? en_cyc_q[b_en] : -1, rc, e_en);
      end
      e_rd = (rc > 0) ? e_en + rc : e_en;
      bad = 0;
      for (int i = 0; i < imin(imin(nr, no), ed); i++)
        if (rd_addr_q[b_rd+i] !== 64'(8*i) || out_q[b_out+i] !== dmem[i]) bad++;
      vectors++;
      if (nr !== ed || no !== ed || bad !== 0 || (nr > 0 && rd_cyc_q[b_rd] !== e_rd)) begin
        miscompares++;
        $display("FAIL rnd%0d_dump: got rd=%0d out=%0d bad=%0d required %0d %0d 0 first_rd=%0d",
                 s, nr, no, bad, ed, ed, e_rd);
      end
      e_done = (ed > 0 && no > 0) ? out_cyc_q[b_out+no-1] + 1 : e_rd;
      vectors++;
      if (done_cyc_q.size() - b_done !== 1 || done_cyc_q[b_done] !== e_done) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got n=%0d c=%0d required 1 %0d", s,
                 done_cyc_q.size() - b_done, done_cyc_q[b_done], e_done);
      end
      vectors++;
      if (busy_cnt - b_busy !== e_done - s_start) begin
        miscompares++;
        $display("FAIL rnd%0d_busy: got %0d required %0d", s, busy_cnt - b_busy, e_done - s_start);
      end
      vectors++;
      if (viol_fixed - b_vf !== 0 || viol_excl - b_vx !== 0 || viol_hold - b_vh !== 0) begin
        miscompares++;
        $display("FAIL rnd%0d_protocol: got fixed=%0d excl=%0d hold=%0d required 0", s,
                 viol_fixed - b_vf, viol_excl - b_vx, viol_hold - b_vh);
      end
    end
  endtask

  task automatic test_abort();
    int k, nwr, nrd, nen;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; prog_len = '0; run_cycles = 32'd50; dump_len = LW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 10 && !cpu_enable; k++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    vectors++;
    if ({cpu_enable, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_run: got enable/busy=%b required 00", {cpu_enable, busy});
    end
    @(posedge clk); #1;
    arst = 1'b0;
    nwr = wr_addr_q.size(); nrd = rd_addr_q.size(); nen = en_cyc_q.size();
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (wr_addr_q.size() !== nwr || rd_addr_q.size() !== nrd || en_cyc_q.size() !== nen) begin
      miscompares++;
      $display("FAIL abort_quiet: got wr=%0d rd=%0d en=%0d new strobes required 0",
               wr_addr_q.size() - nwr, rd_addr_q.size() - nrd, en_cyc_q.size() - nen);
    end
    start = 1'b1; prog_len = '0; run_cycles = '0; dump_len = LW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 10 && !out_valid; k++) begin @(posedge clk); #1; end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_wait_reach: out_valid=%b required 1", out_valid);
    end
    #3 arst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, ren_ext_2, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_wait: got valid/ren/busy=%b required 000", {out_valid, ren_ext_2, busy});
    end
    @(posedge clk); #1;
    arst = 1'b0;
    for (int i = 0; i < 600; i++) stream[i] = $urandom;
    run_session(5, 0, 0, 100, 100, 0);
    vectors++;
    if (wr_addr_q.size() - b_wr !== 5 || wr_addr_q[b_wr] !== 64'd0 || wr_data_q[b_wr] !== stream[0]) begin
      miscompares++;
      $display("FAIL abort_restart: got n=%0d a0=%0h d0=%0h required 5 0 %0h",
               wr_addr_q.size() - b_wr, wr_addr_q[b_wr], wr_data_q[b_wr], stream[0]);
    end
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    prog_len = '0; run_cycles = '0; dump_len = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = {$urandom, $urandom};
    test_reset();
    test_load();
    test_run();
    test_dump();
    test_empty();
    test_clamp();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
